secuenciador_programa: RTL and testbench



---
 rtl/secuenciador_programa.sv | 151 +++++++++++++++
 tb/tb_secuenciador_programa.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_programa.sv
// secuenciador_programa: job sequencer in front of etapa_IF.
// Accepts a job (mode, algorithm, data length), selects the routine for
// fetch, releases the pipeline, waits for the halt opcode in the fetched
// stream, lets the pipeline drain, then pulses done. A watchdog bounds RUN.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        job request, honoured only in IDLE/DONE/ERROR
//   modo, alg    routine selection (0=encrypt/1=decrypt; xor/shift/circ/add)
//   longitud     number of data words of the job
//   instruccion  instruction currently presented by etapa_IF
//   sel_dir      {modo, alg} latched at job accept
//   final_mem    BASE_MEM + longitud latched at job accept (wraps mod 2^32)
//   run_en, busy high in LOAD, RUN and DRAIN
//   done         one-cycle pulse in the first DONE cycle
//   error        sticky watchdog flag, cleared by the next accepted start
//   ciclos       (only with SECUENCIADOR_CICLOS_EN) LOAD+RUN+DRAIN cycles
//                of the last job
//
// Optional feature macro: SECUENCIADOR_CICLOS_EN
module secuenciador_programa #(
    parameter logic [3:0]  HALT_OPCODE  = 4'b1111,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 1024,
    parameter logic [31:0] BASE_MEM     = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        modo,
    input  logic [1:0]  alg,
    input  logic [31:0] longitud,
    input  logic [13:0] instruccion,
    output logic [2:0]  sel_dir,
    output logic [31:0] final_mem,
    output logic        run_en,
    output logic        busy,
    output logic        done,
    output logic        error
`ifdef SECUENCIADOR_CICLOS_EN
    ,
    output logic [31:0] ciclos
`endif
);

    localparam int unsigned WD_W = $clog2(MAX_CYCLES + 1);
    localparam int unsigned DR_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    logic [DR_W-1:0] dr_cnt;
    logic            halt_seen;

    // Only the opcode field matters here; operand bits are deliberately ignored.
    logic unused_operand;
    assign unused_operand = ^instruccion[9:0];
    assign halt_seen      = (instruccion[13:10] == HALT_OPCODE);

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sel_dir   <= 3'b000;
            final_mem <= 32'd0;
            run_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            wd_cnt    <= '0;
            dr_cnt    <= '0;
`ifdef SECUENCIADOR_CICLOS_EN
            ciclos    <= 32'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        sel_dir   <= {modo, alg};
                        final_mem <= BASE_MEM + longitud;
                        error     <= 1'b0;
                        wd_cnt    <= '0;
                        dr_cnt    <= '0;
                        run_en    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_LOAD;
`ifdef SECUENCIADOR_CICLOS_EN
                        ciclos    <= 32'd0;
`endif
                    end
                end

                // etapa_IF picks up the routine address; halt is not looked at yet.
                S_LOAD: begin
                    state <= S_RUN;
`ifdef SECUENCIADOR_CICLOS_EN
                    ciclos <= ciclos + 32'd1;
`endif
                end

                // Halt takes priority over a simultaneous watchdog expiry.
                S_RUN: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
`ifdef SECUENCIADOR_CICLOS_EN
                    ciclos <= ciclos + 32'd1;
`endif
                    if (halt_seen) begin
                        dr_cnt <= '0;
                        state  <= S_DRAIN;
                    end else if (wd_cnt == WD_W'(MAX_CYCLES - 1)) begin
                        error  <= 1'b1;
                        run_en <= 1'b0;
                        busy   <= 1'b0;
                        state  <= S_ERROR;
                    end
                end

                // Let instructions already in ID/EXE/MEM/WB retire.
                S_DRAIN: begin
`ifdef SECUENCIADOR_CICLOS_EN
                    ciclos <= ciclos + 32'd1;
`endif
                    if (dr_cnt == DR_W'(DRAIN_CYCLES - 1)) begin
                        done   <= 1'b1;
                        run_en <= 1'b0;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        dr_cnt <= dr_cnt + DR_W'(1);
                    end
                end

                default: begin
                    run_en <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_programa.sv
// Scoreboard bench for secuenciador_programa: stimulus pushes the expected
// done/error event of each job, a monitor pops and compares on each event.
module tb_secuenciador_programa;

    localparam logic [13:0] INSTR_NOP  = 14'h0123;
    localparam logic [13:0] INSTR_HALT = 14'h3C2A;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        modo;
    logic [1:0]  alg;
    logic [31:0] longitud;
    logic [13:0] instruccion;
    logic [2:0]  sel_dir,   w_sel_dir;
    logic [31:0] final_mem, w_final_mem;
    logic        run_en, busy, done, error;
    logic        w_run_en, w_busy, w_done, w_error;
`ifdef SECUENCIADOR_CICLOS_EN
    logic [31:0] ciclos, w_ciclos;
`endif

    secuenciador_programa #(
        .HALT_OPCODE (4'b1111),
        .DRAIN_CYCLES(4),
        .MAX_CYCLES  (16),
        .BASE_MEM    (32'd0)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .modo       (modo),
        .alg        (alg),
        .longitud   (longitud),
        .instruccion(instruccion),
        .sel_dir    (sel_dir),
        .final_mem  (final_mem),
        .run_en     (run_en),
        .busy       (busy),
        .done       (done),
        .error      (error)
`ifdef SECUENCIADOR_CICLOS_EN
        ,
        .ciclos     (ciclos)
`endif
    );

    // Second instance only for the BASE_MEM wrap-around check.
    secuenciador_programa #(
        .HALT_OPCODE (4'b1111),
        .DRAIN_CYCLES(4),
        .MAX_CYCLES  (16),
        .BASE_MEM    (32'hFFFF_FFF0)
    ) u_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .modo       (modo),
        .alg        (alg),
        .longitud   (longitud),
        .instruccion(instruccion),
        .sel_dir    (w_sel_dir),
        .final_mem  (w_final_mem),
        .run_en     (w_run_en),
        .busy       (w_busy),
        .done       (w_done),
        .error      (w_error)
`ifdef SECUENCIADOR_CICLOS_EN
        ,
        .ciclos     (w_ciclos)
`endif
    );

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [2:0]  sel;
        logic [31:0] fm;
        logic [31:0] cic;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic err_q  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit is_err, input int c, input logic [2:0] s,
                        input logic [31:0] fm, input logic [31:0] cic);
        exp_t e;
        e.is_err = is_err;
        e.cyc    = c;
        e.sel    = s;
        e.fm     = fm;
        e.cic    = cic;
        sb.push_back(e);
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain_sb();
        int k = 0;
        while (sb.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic issue(input logic m, input logic [1:0] a, input logic [31:0] len);
        start    = 1'b1;
        modo     = m;
        alg      = a;
        longitud = len;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic halt_at(input int c);
        at_cycle(c);
        instruccion = INSTR_HALT;
        @(negedge clk);
        instruccion = INSTR_NOP;
    endtask

    // Monitor: every done pulse or error rise must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            err_q = 1'b0;
        end else begin
            if (done || (error && !err_q)) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_event: done=%0b error=%0b at cycle %0d, none expected",
                             done, error, cyc);
                end else begin
                    e = sb.pop_front();
                    check("event_kind_is_error", 32'(error && !done), 32'(e.is_err));
                    check("event_cycle", 32'(cyc), 32'(e.cyc));
                    check("event_sel_dir", 32'(sel_dir), 32'(e.sel));
                    check("event_final_mem", final_mem, e.fm);
                    check("event_busy", 32'(busy), 32'd0);
                    check("event_run_en", 32'(run_en), 32'd0);
`ifdef SECUENCIADOR_CICLOS_EN
                    check("event_ciclos", ciclos, e.cic);
`endif
                end
            end
            err_q = error;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        start       = 1'b0;
        modo        = 1'b0;
        alg         = 2'd0;
        longitud    = 32'd0;
        instruccion = INSTR_NOP;
        repeat (2) @(negedge clk);
        check("reset_sel_dir", 32'(sel_dir), 32'd0);
        check("reset_final_mem", final_mem, 32'd0);
        check("reset_run_en", 32'(run_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done_error", 32'({done, error}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic encrypt/shift job; a halt seen during LOAD must be ignored.
        n = cyc;
        start = 1'b1; modo = 1'b0; alg = 2'd1; longitud = 32'h37;
        @(negedge clk);
        start = 1'b0;
        instruccion = INSTR_HALT;
        check("basic_run_en_next_cycle", 32'(run_en), 32'd1);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_sel_dir", 32'(sel_dir), 32'h1);
        check("basic_final_mem", final_mem, 32'h37);
        @(negedge clk);
        instruccion = INSTR_NOP;
        push(1'b0, n + 9, 3'b001, 32'h37, 32'd8);
        halt_at(n + 4);
        drain_sb();

        // Decrypt/add; a start during RUN must not disturb the latched job.
        n = cyc;
        push(1'b0, n + 11, 3'b111, 32'd100, 32'd10);
        issue(1'b1, 2'd3, 32'd100);
        at_cycle(n + 3);
        issue(1'b0, 2'd0, 32'd5);
        check("ignored_start_sel_dir", 32'(sel_dir), 32'h7);
        check("ignored_start_final_mem", final_mem, 32'd100);
        halt_at(n + 6);
        drain_sb();

        // Watchdog with longitud=0: no halt, error on the 16th RUN cycle.
        n = cyc;
        push(1'b1, n + 18, 3'b010, 32'd0, 32'd17);
        issue(1'b0, 2'd2, 32'd0);
        check("zero_len_final_mem", final_mem, 32'd0);
        drain_sb();
        repeat (3) @(negedge clk);
        check("error_sticky", 32'(error), 32'd1);
        check("error_run_en_low", 32'(run_en), 32'd0);

        // Halt on the last watchdog cycle: drain wins; new start clears error.
        n = cyc;
        push(1'b0, n + 22, 3'b100, 32'd8, 32'd21);
        issue(1'b1, 2'd0, 32'd8);
        check("start_clears_error", 32'(error), 32'd0);
        halt_at(n + 17);
        drain_sb();
        check("no_error_after_tie", 32'(error), 32'd0);

        // final_mem wrap-around on the BASE_MEM instance; halt on 1st RUN cycle.
        n = cyc;
        push(1'b0, n + 7, 3'b011, 32'h20, 32'd6);
        issue(1'b0, 2'd3, 32'h20);
        check("wrap_final_mem", w_final_mem, 32'h10);
        check("nowrap_final_mem", final_mem, 32'h20);
        halt_at(n + 2);
        drain_sb();

        // Reset mid-job with start high: outputs clear at once, no done later.
        n = cyc;
        issue(1'b1, 2'd1, 32'h44);
        at_cycle(n + 3);
        #2;
        start = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midreset_sel_dir", 32'(sel_dir), 32'd0);
        check("midreset_final_mem", final_mem, 32'd0);
        check("midreset_run_en_busy", 32'({run_en, busy}), 32'd0);
        check("midreset_done_error", 32'({done, error}), 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        instruccion = INSTR_HALT;
        repeat (10) @(negedge clk);
        instruccion = INSTR_NOP;
        check("after_reset_idle_busy", 32'(busy), 32'd0);
        check("after_reset_idle_run_en", 32'(run_en), 32'd0);

        repeat (2) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL missing_event: expected at cycle %0d never seen", e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
